// File: rtl/ring_pkg.sv
// Shared types and fault cause codes for the privilege-ring controller.
package ring_pkg;
    typedef enum logic [1:0] {
        ST_KERNEL = 2'd0,
        ST_USER   = 2'd1,
        ST_FAULT  = 2'd2
    } ring_state_e;

    localparam int CAUSE_W = 3;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE      = 3'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_MEM       = 3'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_REG_A     = 3'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_REG_B     = 3'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_REG_W     = 3'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_BAD_JUMP  = 3'd5;
    localparam logic [CAUSE_W-1:0] CAUSE_BAD_ENTRY = 3'd6;
endpackage

// File: rtl/ring_access_checker.sv
// Combinational user-mode access checker; the lowest-numbered cause wins.
module ring_access_checker
    import ring_pkg::*;
#(
    parameter int                ADDR_W        = 16,
    parameter int                SEL_W         = 5,
    parameter logic [ADDR_W-1:0] RING0_END     = 16'h00FF,
    parameter logic [ADDR_W-1:0] RING0_ENTRY   = 16'h0000,
    parameter logic [ADDR_W-1:0] RING0_MEM_END = 16'h000F,
    parameter logic [SEL_W-1:0]  RING0_REGS    = 5'd3
) (
    input  logic               mem_access,
    input  logic [ADDR_W-1:0]  mem_address,
    input  logic [SEL_W-1:0]   a_sel,
    input  logic [SEL_W-1:0]   b_sel,
    input  logic               write_enable,
    input  logic [SEL_W-1:0]   write_sel,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic [31:0]        syscall_reg,
    input  logic               entry_ok,
    output logic               violation,
    output logic [CAUSE_W-1:0] cause,
    output logic [ADDR_W-1:0]  info
);
    // entry_ok marks a pending preemption: the entry jump is then legal without r31.
    always_comb begin
        cause = CAUSE_NONE;
        info  = '0;
        if (mem_access && mem_address <= RING0_MEM_END) begin
            cause = CAUSE_MEM;
            info  = mem_address;
        end else if (a_sel <= RING0_REGS) begin
            cause = CAUSE_REG_A;
            info  = ADDR_W'(a_sel);
        end else if (b_sel <= RING0_REGS) begin
            cause = CAUSE_REG_B;
            info  = ADDR_W'(b_sel);
        end else if (write_enable && write_sel <= RING0_REGS) begin
            cause = CAUSE_REG_W;
            info  = ADDR_W'(write_sel);
        end else if (jump && jump_target <= RING0_END && jump_target != RING0_ENTRY) begin
            cause = CAUSE_BAD_JUMP;
            info  = jump_target;
        end else if (jump && jump_target == RING0_ENTRY && syscall_reg == '0 && !entry_ok) begin
            cause = CAUSE_BAD_ENTRY;
            info  = jump_target;
        end
    end

    assign violation = (cause != CAUSE_NONE);
endmodule

// File: rtl/ring_controller.sv
// Privilege-ring controller: kernel/user tracking, syscall entry/return, sticky faults, timeslice.
module ring_controller
    import ring_pkg::*;
#(
    parameter int                ADDR_W        = 16,
    parameter int                SEL_W         = 5,
    parameter logic [ADDR_W-1:0] RING0_END     = 16'h00FF,
    parameter logic [ADDR_W-1:0] RING0_ENTRY   = 16'h0000,
    parameter logic [ADDR_W-1:0] RING0_MEM_END = 16'h000F,
    parameter logic [SEL_W-1:0]  RING0_REGS    = 5'd3,
    parameter int unsigned       TIMESLICE     = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  io_pc,
    input  logic               io_jump,
    input  logic [ADDR_W-1:0]  io_jumpTarget,
    input  logic               io_memAccess,
    input  logic [ADDR_W-1:0]  io_memAddress,
    input  logic [SEL_W-1:0]   io_aSel,
    input  logic [SEL_W-1:0]   io_bSel,
    input  logic               io_writeEnable,
    input  logic [SEL_W-1:0]   io_writeSel,
    input  logic [31:0]        io_syscallReg,
    output logic [ADDR_W-1:0]  io_programMemoryOffset,
    output logic [ADDR_W-1:0]  io_dataMemoryOffset,
    output logic               io_privileged,
    output logic [ADDR_W-1:0]  io_epc,
    output logic               io_preempt,
    output logic               io_halt,
    output logic [CAUSE_W-1:0] io_faultCause,
    output logic [ADDR_W-1:0]  io_faultInfo
);
    localparam logic [ADDR_W-1:0] USER_OFFSET = RING0_END + ADDR_W'(1);

    ring_state_e        state, state_next;
    logic [31:0]        slice_cnt;
    logic               preempt_pending;
    logic               violation;
    logic [CAUSE_W-1:0] chk_cause;
    logic [ADDR_W-1:0]  chk_info;
    logic               syscall;

    // Counter holds at TIMESLICE until the forced entry jump, which it then legitimises.
    assign preempt_pending = (TIMESLICE != 0) && (slice_cnt == TIMESLICE);
    assign syscall = io_jump && io_jumpTarget == RING0_ENTRY &&
                     (io_syscallReg != '0 || preempt_pending);

    ring_access_checker #(
        .ADDR_W(ADDR_W), .SEL_W(SEL_W), .RING0_END(RING0_END), .RING0_ENTRY(RING0_ENTRY),
        .RING0_MEM_END(RING0_MEM_END), .RING0_REGS(RING0_REGS)
    ) u_checker (
        .mem_access  (io_memAccess),
        .mem_address (io_memAddress),
        .a_sel       (io_aSel),
        .b_sel       (io_bSel),
        .write_enable(io_writeEnable),
        .write_sel   (io_writeSel),
        .jump        (io_jump),
        .jump_target (io_jumpTarget),
        .syscall_reg (io_syscallReg),
        .entry_ok    (preempt_pending),
        .violation   (violation),
        .cause       (chk_cause),
        .info        (chk_info)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_KERNEL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_KERNEL: if (io_jump && io_jumpTarget > RING0_END) state_next = ST_USER;
            ST_USER: begin
                if (violation)    state_next = ST_FAULT;
                else if (syscall) state_next = ST_KERNEL;
            end
            ST_FAULT:  state_next = ST_FAULT;
            default:   state_next = ST_FAULT;
        endcase
    end

    always_comb begin
        io_privileged          = (state != ST_USER);
        io_halt                = (state == ST_FAULT);
        io_programMemoryOffset = (state == ST_USER) ? USER_OFFSET : '0;
        io_dataMemoryOffset    = (state == ST_USER) ? USER_OFFSET : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_epc        <= '0;
            io_preempt    <= 1'b0;
            io_faultCause <= CAUSE_NONE;
            io_faultInfo  <= '0;
            slice_cnt     <= '0;
        end else begin
            io_preempt <= 1'b0;
            if (state == ST_KERNEL && state_next == ST_USER)
                slice_cnt <= '0;
            else if (state == ST_USER && slice_cnt < TIMESLICE)
                slice_cnt <= slice_cnt + 32'd1;
            if (TIMESLICE != 0 && state == ST_USER && state_next == ST_USER &&
                slice_cnt == TIMESLICE - 32'd1)
                io_preempt <= 1'b1;
            if (state == ST_USER && violation) begin
                io_faultCause <= chk_cause;
                io_faultInfo  <= chk_info;
            end else if (state == ST_USER && state_next == ST_KERNEL) begin
                // A preempted instruction was not executed, so it is resumed, not skipped.
                io_epc <= preempt_pending ? io_pc : io_pc + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ring_controller.sv
// Directed self-checking bench for ring_controller (default and TIMESLICE=8 instances).
module tb_ring_controller;
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] pc, target, addr;
    logic        jump, mem, we;
    logic [4:0]  a_sel, b_sel, w_sel;
    logic [31:0] r31;

    logic [15:0] poff, doff, epc, info;
    logic        priv, preempt, halt;
    logic [2:0]  cause;
    logic [15:0] t_poff, t_doff, t_epc, t_info;
    logic        t_priv, t_preempt, t_halt;
    logic [2:0]  t_cause;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        mem;
        logic [15:0] addr;
        logic [4:0]  a, b;
        logic        we;
        logic [4:0]  ws;
        logic        jmp;
        logic [15:0] tgt;
        logic [31:0] r31;
        logic [2:0]  ecause;
        logic [15:0] einfo;
    } vec_t;

    vec_t tbl [9] = '{
        '{1'b1, 16'h000A, 5'd2, 5'd9, 1'b0, 5'd10, 1'b0, 16'h0000, 32'd0, 3'd1, 16'h000A},
        '{1'b1, 16'h000F, 5'd8, 5'd9, 1'b0, 5'd10, 1'b0, 16'h0000, 32'd0, 3'd1, 16'h000F},
        '{1'b1, 16'h0010, 5'd3, 5'd1, 1'b0, 5'd10, 1'b0, 16'h0000, 32'd0, 3'd2, 16'h0003},
        '{1'b0, 16'h0100, 5'd8, 5'd1, 1'b1, 5'd0,  1'b0, 16'h0000, 32'd0, 3'd3, 16'h0001},
        '{1'b0, 16'h0100, 5'd8, 5'd9, 1'b1, 5'd3,  1'b1, 16'h0050, 32'd0, 3'd4, 16'h0003},
        '{1'b0, 16'h0100, 5'd8, 5'd9, 1'b0, 5'd10, 1'b1, 16'h0050, 32'd0, 3'd5, 16'h0050},
        '{1'b0, 16'h0100, 5'd8, 5'd9, 1'b0, 5'd10, 1'b1, 16'h00FF, 32'd0, 3'd5, 16'h00FF},
        '{1'b0, 16'h0100, 5'd8, 5'd9, 1'b0, 5'd10, 1'b1, 16'h0000, 32'd0, 3'd6, 16'h0000},
        '{1'b0, 16'h0100, 5'd1, 5'd9, 1'b0, 5'd10, 1'b1, 16'h0000, 32'd5, 3'd2, 16'h0001}
    };

    ring_controller dut (
        .clock(clock), .reset(reset), .io_pc(pc), .io_jump(jump), .io_jumpTarget(target),
        .io_memAccess(mem), .io_memAddress(addr), .io_aSel(a_sel), .io_bSel(b_sel),
        .io_writeEnable(we), .io_writeSel(w_sel), .io_syscallReg(r31),
        .io_programMemoryOffset(poff), .io_dataMemoryOffset(doff), .io_privileged(priv),
        .io_epc(epc), .io_preempt(preempt), .io_halt(halt), .io_faultCause(cause),
        .io_faultInfo(info)
    );

    ring_controller #(.TIMESLICE(8)) dut_ts (
        .clock(clock), .reset(reset), .io_pc(pc), .io_jump(jump), .io_jumpTarget(target),
        .io_memAccess(mem), .io_memAddress(addr), .io_aSel(a_sel), .io_bSel(b_sel),
        .io_writeEnable(we), .io_writeSel(w_sel), .io_syscallReg(r31),
        .io_programMemoryOffset(t_poff), .io_dataMemoryOffset(t_doff), .io_privileged(t_priv),
        .io_epc(t_epc), .io_preempt(t_preempt), .io_halt(t_halt), .io_faultCause(t_cause),
        .io_faultInfo(t_info)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        pc = 16'h0120; jump = 1'b0; target = 16'h0000; mem = 1'b0; addr = 16'h0100;
        a_sel = 5'd8; b_sel = 5'd9; we = 1'b0; w_sel = 5'd10; r31 = 32'd0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic go_user();
        idle(); jump = 1'b1; target = 16'h0120;
        step();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #3;
        chk("rst_poff", 32'(poff), 32'h0);
        chk("rst_doff", 32'(doff), 32'h0);
        chk("rst_priv", 32'(priv), 32'h1);
        chk("rst_epc", 32'(epc), 32'h0);
        chk("rst_preempt", 32'(preempt), 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_cause", 32'(cause), 32'h0);
        chk("rst_info", 32'(info), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Kernel boundary: 0x00FF keeps kernel, 0x0100 enters user.
        jump = 1'b1; target = 16'h00FF; step();
        chk("k_jump_ff_priv", 32'(priv), 32'h1);
        target = 16'h0100; step();
        chk("k_jump_100_priv", 32'(priv), 32'h0);
        chk("user_poff", 32'(poff), 32'h0100);
        chk("user_doff", 32'(doff), 32'h0100);

        // Syscall then immediate return on the next edge.
        idle(); pc = 16'h0130; r31 = 32'd5; jump = 1'b1; target = 16'h0000; step();
        chk("sys_priv", 32'(priv), 32'h1);
        chk("sys_poff", 32'(poff), 32'h0);
        chk("sys_epc", 32'(epc), 32'h0131);
        chk("sys_halt", 32'(halt), 32'h0);
        idle(); mem = 1'b1; addr = 16'h0005; a_sel = 5'd0; jump = 1'b1; target = 16'h0131; step();
        chk("ret_priv", 32'(priv), 32'h0);
        chk("kern_nocheck_halt", 32'(halt), 32'h0);

        // Just-legal accesses in user mode.
        idle(); mem = 1'b1; addr = 16'h0010; a_sel = 5'd4; b_sel = 5'd4; we = 1'b1; w_sel = 5'd4; step();
        chk("legal_halt", 32'(halt), 32'h0);
        chk("legal_priv", 32'(priv), 32'h0);

        // EPC wraps at the top of the address space.
        idle(); pc = 16'hFFFF; r31 = 32'd1; jump = 1'b1; target = 16'h0000; step();
        chk("wrap_epc", 32'(epc), 32'h0000);
        chk("wrap_priv", 32'(priv), 32'h1);
        go_user();
        chk("reenter_priv", 32'(priv), 32'h0);

        // Fault, stickiness, then asynchronous reset between edges.
        mem = 1'b1; addr = 16'h000A; a_sel = 5'd2; step();
        chk("flt_halt", 32'(halt), 32'h1);
        chk("flt_cause", 32'(cause), 32'h1);
        chk("flt_info", 32'(info), 32'h000A);
        chk("flt_poff", 32'(poff), 32'h0);
        chk("flt_priv", 32'(priv), 32'h1);
        idle(); jump = 1'b1; target = 16'h0200; step(); step();
        chk("sticky_halt", 32'(halt), 32'h1);
        chk("sticky_cause", 32'(cause), 32'h1);
        chk("sticky_priv", 32'(priv), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("arst_halt", 32'(halt), 32'h0);
        chk("arst_priv", 32'(priv), 32'h1);
        chk("arst_cause", 32'(cause), 32'h0);
        chk("arst_info", 32'(info), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Per-cause vectors, each from a fresh reset.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            go_user();
            mem = tbl[i].mem; addr = tbl[i].addr; a_sel = tbl[i].a; b_sel = tbl[i].b;
            we = tbl[i].we; w_sel = tbl[i].ws; jump = tbl[i].jmp; target = tbl[i].tgt;
            r31 = tbl[i].r31;
            step();
            chk($sformatf("vec%0d_halt", i), 32'(halt), 32'h1);
            chk($sformatf("vec%0d_cause", i), 32'(cause), 32'(tbl[i].ecause));
            chk($sformatf("vec%0d_info", i), 32'(info), 32'(tbl[i].einfo));
            chk($sformatf("vec%0d_priv", i), 32'(priv), 32'h1);
            idle(); jump = 1'b1; target = 16'h0300; step();
            chk($sformatf("vec%0d_sticky", i), 32'(cause), 32'(tbl[i].ecause));
        end
        chk("vec8_epc_unchanged", 32'(epc), 32'h0);

        // Timeslice: preempt after 8 user cycles, entry jump then legal without r31.
        do_reset();
        go_user();
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("ts_preempt_%0d", k), 32'(t_preempt), 32'(k == 8));
            chk($sformatf("nots_preempt_%0d", k), 32'(preempt), 32'h0);
        end
        pc = 16'h0140; r31 = 32'd0; jump = 1'b1; target = 16'h0000; step();
        chk("ts_entry_priv", 32'(t_priv), 32'h1);
        chk("ts_entry_halt", 32'(t_halt), 32'h0);
        chk("ts_entry_epc", 32'(t_epc), 32'h0140);
        chk("nots_entry_halt", 32'(halt), 32'h1);
        chk("nots_entry_cause", 32'(cause), 32'h6);
        go_user();
        chk("ts_reenter_priv", 32'(t_priv), 32'h0);
        step(); step();
        chk("ts_cleared_preempt", 32'(t_preempt), 32'h0);
        r31 = 32'd0; jump = 1'b1; target = 16'h0000; step();
        chk("ts_cleared_halt", 32'(t_halt), 32'h1);
        chk("ts_cleared_cause", 32'(t_cause), 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
